// File: rtl/xout_accum.sv
// xout_accum: groups NSAMPLES unsigned XOUT results from the upstream IfEnt stage
// and emits one beat carrying the group sum and maximum.
//
// Ports
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous reset, active-low
//   clear      in   1        synchronous flush of the current group
//   xout       in   DATA_W   incoming sample
//   in_valid   in   1        xout valid this cycle
//   in_ready   out  1        block accepts xout this cycle (from state only)
//   sum        out  SUM_W    group sum, unsigned
//   smax       out  DATA_W   group maximum, unsigned
//   out_valid  out  1        sum/smax hold a completed group
//   out_ready  in   1        downstream consumes the group
//
// State  | Meaning
// IDLE   | no samples collected, waiting for the first beat of a group
// ACCUM  | 1..NSAMPLES-1 samples collected
// EMIT   | group complete, result presented until out_ready
module xout_accum #(
  parameter int DATA_W   = 16,
  parameter int NSAMPLES = 4,
  parameter int SUM_W    = DATA_W + $clog2(NSAMPLES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [DATA_W-1:0] xout,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SUM_W-1:0]  sum,
  output logic [DATA_W-1:0] smax,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CNT_W = $clog2(NSAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSAMPLES);

  if (NSAMPLES < 1) begin : g_bad_nsamples
    $error("xout_accum: NSAMPLES must be >= 1");
  end
  if (SUM_W < DATA_W + $clog2(NSAMPLES)) begin : g_bad_sum_w
    $error("xout_accum: SUM_W too narrow to hold a full group sum");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [SUM_W-1:0]  acc, acc_nxt;
  logic [DATA_W-1:0] mx, mx_nxt;
  logic [SUM_W-1:0]  sum_nxt;
  logic [DATA_W-1:0] smax_nxt;
  logic              out_valid_nxt;

  logic              accept;
  logic [SUM_W-1:0]  xout_ext;
  logic [SUM_W-1:0]  acc_add;
  logic [DATA_W-1:0] mx_sel;
  logic [CNT_W-1:0]  cnt_inc;

  assign in_ready = (state != EMIT);
  assign accept   = in_valid && in_ready;
  assign xout_ext = SUM_W'(xout);

  // The first beat of a group seeds the accumulators instead of adding to
  // whatever the previous group left behind.
  assign acc_add = (state == IDLE) ? xout_ext : acc + xout_ext;
  assign mx_sel  = ((state == IDLE) || (xout > mx)) ? xout : mx;
  assign cnt_inc = (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    acc_nxt       = acc;
    mx_nxt        = mx;
    sum_nxt       = sum;
    smax_nxt      = smax;
    out_valid_nxt = out_valid;

    if (clear) begin
      // sum/smax keep the last emitted result; only the group in flight is dropped
      state_nxt     = IDLE;
      cnt_nxt       = '0;
      out_valid_nxt = 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_nxt = acc_add;
            mx_nxt  = mx_sel;
            cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_LAST) begin
              state_nxt     = EMIT;
              sum_nxt       = acc_add;
              smax_nxt      = mx_sel;
              out_valid_nxt = 1'b1;
            end else begin
              state_nxt = ACCUM;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            state_nxt     = IDLE;
            cnt_nxt       = '0;
            out_valid_nxt = 1'b0;
          end
        end
        default: begin
          state_nxt     = IDLE;
          cnt_nxt       = '0;
          out_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      mx        <= '0;
      sum       <= '0;
      smax      <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      acc       <= acc_nxt;
      mx        <= mx_nxt;
      sum       <= sum_nxt;
      smax      <= smax_nxt;
      out_valid <= out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_xout_accum.sv
// Testbench for xout_accum: directed scenarios plus random traffic. A reference
// model keeps the accepted samples of the open group in a queue and computes
// sum/max with plain arithmetic when the group fills; the monitor pops expected
// results whenever the DUT completes an emit.
module tb_xout_accum;

  localparam int DATA_W   = 16;
  localparam int NSAMPLES = 4;
  localparam int SUM_W    = DATA_W + $clog2(NSAMPLES);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic [DATA_W-1:0] xout;
  logic              in_valid;
  logic              in_ready;
  logic [SUM_W-1:0]  sum;
  logic [DATA_W-1:0] smax;
  logic              out_valid;
  logic              out_ready;

  xout_accum #(.DATA_W(DATA_W), .NSAMPLES(NSAMPLES), .SUM_W(SUM_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .xout      (xout),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .smax      (smax),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model state
  longint grp[$];
  longint exp_sum[$];
  longint exp_max[$];
  bit     emit_pending = 1'b0;
  longint last_sum = 0;
  longint last_max = 0;

  // Model: at each negedge, check what the DUT shows now, then advance the
  // model to what the coming rising edge should produce.
  always @(negedge clk) begin
    if (!rst_n) begin
      grp.delete();
      exp_sum.delete();
      exp_max.delete();
      emit_pending = 1'b0;
      last_sum = 0;
      last_max = 0;
    end else begin
      chk("in_ready",  longint'(in_ready),  longint'(!emit_pending));
      chk("out_valid", longint'(out_valid), longint'(emit_pending));
      chk("sum_hold",  longint'(sum),       last_sum);
      chk("smax_hold", longint'(smax),      last_max);
      if (clear) begin
        if (emit_pending) begin
          void'(exp_sum.pop_back());
          void'(exp_max.pop_back());
        end
        emit_pending = 1'b0;
        grp.delete();
      end else if (emit_pending) begin
        if (out_ready) emit_pending = 1'b0;
      end else if (in_valid) begin
        grp.push_back(longint'(xout));
        if (grp.size() == NSAMPLES) begin
          longint s, m;
          s = 0;
          m = 0;
          foreach (grp[i]) begin
            s += grp[i];
            if (grp[i] > m) m = grp[i];
          end
          exp_sum.push_back(s);
          exp_max.push_back(m);
          last_sum = s;
          last_max = m;
          emit_pending = 1'b1;
          grp.delete();
        end
      end
    end
  end

  // Monitor: compare the presented group against the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && !clear) begin
      if (exp_sum.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        chk("group_sum", longint'(sum),  exp_sum[0]);
        chk("group_max", longint'(smax), exp_max[0]);
        if (out_ready) begin
          void'(exp_sum.pop_front());
          void'(exp_max.pop_front());
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic c);
    in_valid  = v;
    xout      = d;
    out_ready = r;
    clear     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic pulse_reset_check(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_out_valid"}, longint'(out_valid), 0);
    chk({tag, "_sum"},       longint'(sum),       0);
    chk({tag, "_smax"},      longint'(smax),      0);
    chk({tag, "_in_ready"},  longint'(in_ready),  1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    xout      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_sum",       longint'(sum),       0);
    chk("rst_smax",      longint'(smax),      0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready",  longint'(in_ready),  1);

    // T1 basic
    cyc(1, 16'd10, 1, 0); cyc(1, 16'd20, 1, 0); cyc(1, 16'd30, 1, 0); cyc(1, 16'd40, 1, 0);
    chk("t1_out_valid", longint'(out_valid), 1);
    chk("t1_sum",       longint'(sum),       100);
    chk("t1_smax",      longint'(smax),      40);
    idle(2);

    // T2 extremes
    for (int i = 0; i < 4; i++) cyc(1, 16'hFFFF, 1, 0);
    chk("t2_sum_max", longint'(sum),  longint'(18'h3FFFC));
    chk("t2_smax",    longint'(smax), 65535);
    idle(1);
    for (int i = 0; i < 4; i++) cyc(1, 16'h0000, 1, 0);
    chk("t2_sum_zero",  longint'(sum),  0);
    chk("t2_smax_zero", longint'(smax), 0);
    idle(2);

    // T3 backpressure with a pending beat of 7
    cyc(1, 16'd1, 0, 0); cyc(1, 16'd2, 0, 0); cyc(1, 16'd3, 0, 0); cyc(1, 16'd4, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 16'd7, 0, 0);
    cyc(1, 16'd7, 1, 0);
    cyc(1, 16'd7, 1, 0);
    cyc(1, 16'd8, 1, 0); cyc(1, 16'd9, 1, 0); cyc(1, 16'd10, 1, 0);
    chk("t3_sum",  longint'(sum),  34);
    chk("t3_smax", longint'(smax), 10);
    idle(2);

    // T4 gaps
    cyc(1, 16'd5, 1, 0); idle(3); cyc(1, 16'd9, 1, 0); idle(1);
    cyc(1, 16'd1, 1, 0);
    chk("t4_no_early_out", longint'(out_valid), 0);
    cyc(1, 16'd2, 1, 0);
    chk("t4_sum",  longint'(sum),  17);
    chk("t4_smax", longint'(smax), 9);
    idle(2);

    // T5 clear mid-group (beat during clear is dropped) and during EMIT
    cyc(1, 16'd100, 1, 0); cyc(1, 16'd200, 1, 0); cyc(1, 16'd55, 1, 1);
    cyc(1, 16'd1, 1, 0); cyc(1, 16'd2, 1, 0); cyc(1, 16'd3, 1, 0); cyc(1, 16'd4, 1, 0);
    chk("t5_sum",  longint'(sum),  10);
    chk("t5_smax", longint'(smax), 4);
    idle(1);
    cyc(1, 16'd11, 0, 0); cyc(1, 16'd12, 0, 0); cyc(1, 16'd13, 0, 0); cyc(1, 16'd14, 0, 0);
    cyc(0, 16'd0, 0, 1);
    chk("t5_clear_emit_drop", longint'(out_valid), 0);
    chk("t5_clear_sum_hold",  longint'(sum),       50);
    idle(2);

    // T6 reset mid-group and during EMIT
    cyc(1, 16'd21, 1, 0); cyc(1, 16'd22, 1, 0);
    pulse_reset_check("t6_mid");
    cyc(1, 16'd31, 0, 0); cyc(1, 16'd32, 0, 0); cyc(1, 16'd33, 0, 0); cyc(1, 16'd34, 0, 0);
    cyc(0, 16'd0, 0, 0);
    pulse_reset_check("t6_emit");
    cyc(1, 16'd2, 1, 0); cyc(1, 16'd6, 1, 0); cyc(1, 16'd3, 1, 0); cyc(1, 16'd5, 1, 0);
    chk("t6_fresh_sum",  longint'(sum),  16);
    chk("t6_fresh_smax", longint'(smax), 6);
    idle(2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [DATA_W-1:0] d;
      case ($urandom_range(0, 7))
        0:       d = 16'hFFFF;
        1:       d = 16'h0000;
        default: d = 16'($urandom);
      endcase
      cyc(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 1) == 1), ($urandom_range(0, 59) == 0));
    end

    idle(4);
    chk("drain_queue_empty", longint'(exp_sum.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
